// File: rtl/decode_ctrl_pkg.sv
// Shared types and constants for the decode-stage input controller.
// Owns the controller state encoding and the stall counter width.
package stage;

  localparam int STALL_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2,
    FLUSH = 2'd3
  } DecCtrlState;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
    input logic [STALL_CNT_WIDTH-1:0] value
  );
    return (&value) ? value : value + STALL_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/decode_ctrl_skid_fifo2.sv
// Two-entry in-order buffer between fetch and decode.
// One-bit pointers wrap naturally; clear empties it in one cycle.
module skid_fifo2 #(
  parameter int ADDR_W = 30,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [INSN_W-1:0] push_insn,
  output logic [1:0]        occupancy,
  output logic [ADDR_W-1:0] head_addr,
  output logic [INSN_W-1:0] head_insn
);

  logic [ADDR_W-1:0] r_addr [2];
  logic [INSN_W-1:0] r_insn [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push && (r_count != 2'd2);
  assign w_do_pop  = pop && (r_count != 2'd0);

  // NOTE: entry storage is deliberately left out of reset; it is only read
  // when occupancy says it holds a valid beat, so reset would cost muxes for nothing.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr[r_wptr] <= push_addr;
      r_insn[r_wptr] <= push_insn;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (clear) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign occupancy = r_count;
  assign head_addr = r_addr[r_rptr];
  assign head_insn = r_insn[r_rptr];

endmodule

// File: rtl/decode_ctrl.sv
// Fetch-to-decode controller: 2-entry buffer, flush/redirect FSM and a
// saturating downstream-stall counter.
module decode_ctrl
  import stage::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [ADDR_WIDTH-1:2]      fetch_addr,
  input  logic [INSN_WIDTH-1:0]      fetch_insn,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  output logic [ADDR_WIDTH-1:2]      dec_addr,
  output logic [INSN_WIDTH-1:0]      dec_insn,
  input  logic                       dec_ready,
  input  logic                       flush,
  input  logic [ADDR_WIDTH-1:2]      flush_addr,
  output logic                       redirect_valid,
  output logic [ADDR_WIDTH-1:2]      redirect_addr,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int AW = ADDR_WIDTH - 2;

  DecCtrlState                r_state;
  DecCtrlState                w_state_next;
  logic [AW-1:0]              r_redirect_addr;
  logic [STALL_CNT_WIDTH-1:0] r_stall_count;

  logic       w_push;
  logic       w_pop;
  logic       w_flush_take;
  logic [1:0] w_occ;

  // Handshake qualifiers depend only on registered state and the flush input,
  // so dec_ready never reaches fetch_ready combinationally.
  assign fetch_ready  = (w_occ != 2'd2) && (r_state != FLUSH) && !flush;
  assign dec_valid    = (w_occ != 2'd0) && (r_state != FLUSH);
  assign w_push       = fetch_valid && fetch_ready;
  assign w_pop        = dec_valid && dec_ready;
  assign w_flush_take = flush && (r_state != FLUSH);

  skid_fifo2 #(
    .ADDR_W (AW),
    .INSN_W (INSN_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (w_flush_take),
    .push_addr (fetch_addr),
    .push_insn (fetch_insn),
    .occupancy (w_occ),
    .head_addr (dec_addr),
    .head_insn (dec_insn)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= EMPTY;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == FLUSH) begin
      w_state_next = EMPTY;
    end else if (flush) begin
      w_state_next = FLUSH;
    end else begin
      case (r_state)
        EMPTY: if (w_push) w_state_next = ONE;
        ONE: begin
          if (w_push && !w_pop)      w_state_next = FULL;
          else if (!w_push && w_pop) w_state_next = EMPTY;
        end
        FULL:    if (w_pop) w_state_next = ONE;
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // The redirect target is captured only when a flush is accepted, so a
  // flush repeated during FLUSH cannot overwrite the pulse's address.
  always_ff @(posedge clk) begin
    if (!rst)              r_redirect_addr <= '0;
    else if (w_flush_take) r_redirect_addr <= flush_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst)                         r_stall_count <= '0;
    else if (dec_valid && !dec_ready) r_stall_count <= sat_inc(r_stall_count);
  end

  assign redirect_valid = (r_state == FLUSH);
  assign redirect_addr  = r_redirect_addr;
  assign occupancy      = w_occ;
  assign stall_count    = r_stall_count;

endmodule
